match_sequencer: RTL and testbench

- Frame-rate controller that sequences the air-hockey match around the ball datapath.
- Produces the 8-bit gameState consumed by the ball, paddles and renderer.
- Detects goals from ball/screen-edge collisions and keeps both scores.
- Times the serve and post-goal pauses, and sets ball speed from the paddle-hit rally count.

---
 rtl/match_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_match_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// ---------------------------------------------------------------------------
// match_sequencer
//
// Frame-rate controller for the air-hockey match. It owns the match state
// machine (title, serve, play, goal pause, game over and optional pause),
// keeps both scores, times the serve and post-goal pauses, and raises the
// ball speed as the paddle-hit rally grows.
//
// Every state update is qualified by the one-cycle vSyncStart frame tick, so
// all timing here is counted in frames, not pixel clocks.
//
// Optional feature macro: MATCH_SEQUENCER_PAUSE_EN
//   Defined   : buttons[1] toggles PLAYING <-> PAUSED (state code 5); start
//               while paused abandons the match back to TITLE.
//   Undefined : buttons[1] is ignored and state code 5 never appears.
//
// Ports
//   pixelClock                  in   system pixel clock
//   resetN                      in   asynchronous active-low reset
//   vSyncStart                  in   one-cycle frame tick
//   buttons[7:0]                in   bit0 = start, bit1 = pause
//   collisionBallScreenLeft     in   ball at left edge  -> computer scores
//   collisionBallScreenRight    in   ball at right edge -> player scores
//   collisionBallPlayerPaddle   in   ball touching player paddle
//   collisionBallComputerPaddle in   ball touching computer paddle
//   gameState[7:0]              out  current state code (0..5)
//   playerScore[3:0]            out  player goals, 0..WIN_SCORE
//   computerScore[3:0]          out  computer goals, 0..WIN_SCORE
//   ballSpeed[7:0]              out  speed applied to both ball axes
//   countdown[7:0]              out  frames left in SERVE/GOAL, else 0
//   serveRight                  out  1 = next serve travels toward computer
// ---------------------------------------------------------------------------
module match_sequencer #(
  parameter int SERVE_FRAMES  = 120,
  parameter int GOAL_FRAMES   = 60,
  parameter int WIN_SCORE     = 7,
  parameter int BASE_SPEED    = 5,
  parameter int MAX_SPEED     = 12,
  parameter int HITS_PER_STEP = 4
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       vSyncStart,
  input  logic [7:0] buttons,
  input  logic       collisionBallScreenLeft,
  input  logic       collisionBallScreenRight,
  input  logic       collisionBallPlayerPaddle,
  input  logic       collisionBallComputerPaddle,
  output logic [7:0] gameState,
  output logic [3:0] playerScore,
  output logic [3:0] computerScore,
  output logic [7:0] ballSpeed,
  output logic [7:0] countdown,
  output logic       serveRight
);

  // State codes are part of the interface: the ball, paddles and renderer
  // all decode gameState numerically.
  typedef enum logic [2:0] {
    TITLE    = 3'd0,
    SERVE    = 3'd1,
    PLAYING  = 3'd2,
    GOAL     = 3'd3,
    GAMEOVER = 3'd4,
    PAUSED   = 3'd5
  } stateT;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] GOAL_LOAD  = 8'(GOAL_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] BASE       = 8'(BASE_SPEED);
  localparam logic [7:0] MAX        = 8'(MAX_SPEED);
  localparam logic [7:0] HIT_LAST   = 8'(HITS_PER_STEP - 1);

  stateT      state;
  logic [7:0] hitCount;

  // Previous-tick samples used for press / first-contact detection.
  logic       prevStart;
  logic       prevPaddle;

  logic       startPress;
  logic       paddleTouch;
  logic       hitEdge;
  logic [3:0] playerNext;
  logic [3:0] computerNext;

`ifdef MATCH_SEQUENCER_PAUSE_EN
  logic       prevPause;
  logic       pausePress;
  logic       unusedButtons;

  assign unusedButtons = ^buttons[7:2];
`else
  logic       unusedButtons;

  assign unusedButtons = ^buttons[7:1];
`endif

  // Press and contact events are edges measured at frame rate, so a button
  // or paddle contact that spans several frames still counts only once.
  assign startPress  = buttons[0] & ~prevStart;
  assign paddleTouch = collisionBallPlayerPaddle | collisionBallComputerPaddle;
  assign hitEdge     = paddleTouch & ~prevPaddle;
`ifdef MATCH_SEQUENCER_PAUSE_EN
  assign pausePress  = buttons[1] & ~prevPause;
`endif

  assign playerNext   = playerScore + 4'd1;
  assign computerNext = computerScore + 4'd1;

  assign gameState = {5'd0, state};

  // Edge-detect history. Sampled on every frame tick regardless of state so
  // that a button held across a state change is not seen as a new press.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      prevStart  <= 1'b0;
      prevPaddle <= 1'b0;
`ifdef MATCH_SEQUENCER_PAUSE_EN
      prevPause  <= 1'b0;
`endif
    end else if (vSyncStart) begin
      prevStart  <= buttons[0];
      prevPaddle <= paddleTouch;
`ifdef MATCH_SEQUENCER_PAUSE_EN
      prevPause  <= buttons[1];
`endif
    end
  end

  // Match state machine with all of its registered outputs. Entering SERVE
  // always reloads the serve timer, resets the ball speed and clears the
  // rally hit counter, whichever state it is entered from.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state         <= TITLE;
      playerScore   <= 4'd0;
      computerScore <= 4'd0;
      ballSpeed     <= BASE;
      countdown     <= 8'd0;
      serveRight    <= 1'b1;
      hitCount      <= 8'd0;
    end else if (vSyncStart) begin
      case (state)
        TITLE: begin
          if (startPress) begin
            playerScore   <= 4'd0;
            computerScore <= 4'd0;
            serveRight    <= 1'b1;
            countdown     <= SERVE_LOAD;
            ballSpeed     <= BASE;
            hitCount      <= 8'd0;
            state         <= SERVE;
          end
        end

        SERVE: begin
          if (countdown == 8'd0) begin
            state <= PLAYING;
          end else begin
            countdown <= countdown - 8'd1;
          end
        end

        // Left-edge goal outranks right-edge goal, and any goal outranks a
        // paddle hit on the same frame.
        PLAYING: begin
`ifdef MATCH_SEQUENCER_PAUSE_EN
          if (pausePress) begin
            state <= PAUSED;
          end else
`endif
          if (collisionBallScreenLeft) begin
            computerScore <= computerNext;
            serveRight    <= 1'b1;
            if (computerNext == WIN) begin
              state <= GAMEOVER;
            end else begin
              countdown <= GOAL_LOAD;
              state     <= GOAL;
            end
          end else if (collisionBallScreenRight) begin
            playerScore <= playerNext;
            serveRight  <= 1'b0;
            if (playerNext == WIN) begin
              state <= GAMEOVER;
            end else begin
              countdown <= GOAL_LOAD;
              state     <= GOAL;
            end
          end else if (hitEdge) begin
            // Every HITS_PER_STEP hits bump the speed by one, capped at MAX.
            if (hitCount == HIT_LAST) begin
              hitCount <= 8'd0;
              if (ballSpeed < MAX) begin
                ballSpeed <= ballSpeed + 8'd1;
              end
            end else begin
              hitCount <= hitCount + 8'd1;
            end
          end
        end

        GOAL: begin
          if (countdown == 8'd0) begin
            countdown <= SERVE_LOAD;
            ballSpeed <= BASE;
            hitCount  <= 8'd0;
            state     <= SERVE;
          end else begin
            countdown <= countdown - 8'd1;
          end
        end

        GAMEOVER: begin
          if (startPress) begin
            playerScore   <= 4'd0;
            computerScore <= 4'd0;
            serveRight    <= 1'b1;
            countdown     <= SERVE_LOAD;
            ballSpeed     <= BASE;
            hitCount      <= 8'd0;
            state         <= SERVE;
          end
        end

`ifdef MATCH_SEQUENCER_PAUSE_EN
        // Everything is frozen while paused; only the two buttons act.
        PAUSED: begin
          if (startPress) begin
            playerScore   <= 4'd0;
            computerScore <= 4'd0;
            state         <= TITLE;
          end else if (pausePress) begin
            state <= PLAYING;
          end
        end
`endif

        default: begin
          state <= TITLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// ---------------------------------------------------------------------------
// tb_match_sequencer
//
// Self-checking bench for match_sequencer: a table of directed frame
// vectors with hand-derived expectations, hand-written corner sequences
// (asynchronous reset, speed ramp and saturation, match end, pause), then
// randomized frames compared against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_match_sequencer;

  localparam int SERVE_FRAMES  = 120;
  localparam int GOAL_FRAMES   = 60;
  localparam int WIN_SCORE     = 7;
  localparam int BASE_SPEED    = 5;
  localparam int MAX_SPEED     = 12;
  localparam int HITS_PER_STEP = 4;

  localparam int ST_TITLE    = 0;
  localparam int ST_SERVE    = 1;
  localparam int ST_PLAYING  = 2;
  localparam int ST_GOAL     = 3;
  localparam int ST_GAMEOVER = 4;
  localparam int ST_PAUSED   = 5;

  logic       pixelClock = 1'b0;
  logic       resetN;
  logic       vSyncStart;
  logic [7:0] buttons;
  logic       collisionBallScreenLeft;
  logic       collisionBallScreenRight;
  logic       collisionBallPlayerPaddle;
  logic       collisionBallComputerPaddle;
  logic [7:0] gameState;
  logic [3:0] playerScore;
  logic [3:0] computerScore;
  logic [7:0] ballSpeed;
  logic [7:0] countdown;
  logic       serveRight;

  int checks   = 0;
  int failures = 0;

  // Reference model: scores, state code and timers as plain integers. The
  // speed is derived from the total number of hits since the last serve.
  int   mState;
  int   mPlayer;
  int   mComputer;
  int   mHitsSinceServe;
  int   mCountdown;
  int   mServeRight;
  logic mPrevStart;
  logic mPrevPause;
  logic mPrevPaddle;

  typedef struct {
    logic [7:0] buttons;
    logic       left;
    logic       right;
    logic       pPad;
    logic       cPad;
    int         reps;
    int         expState;
    int         expPlayer;
    int         expComputer;
    int         expSpeed;
    int         expCountdown;
    int         expServeRight;
  } vecT;

  vecT vectors[$];

  always #5 pixelClock = ~pixelClock;

  match_sequencer #(
    .SERVE_FRAMES  (SERVE_FRAMES),
    .GOAL_FRAMES   (GOAL_FRAMES),
    .WIN_SCORE     (WIN_SCORE),
    .BASE_SPEED    (BASE_SPEED),
    .MAX_SPEED     (MAX_SPEED),
    .HITS_PER_STEP (HITS_PER_STEP)
  ) dut (
    .pixelClock                  (pixelClock),
    .resetN                      (resetN),
    .vSyncStart                  (vSyncStart),
    .buttons                     (buttons),
    .collisionBallScreenLeft     (collisionBallScreenLeft),
    .collisionBallScreenRight    (collisionBallScreenRight),
    .collisionBallPlayerPaddle   (collisionBallPlayerPaddle),
    .collisionBallComputerPaddle (collisionBallComputerPaddle),
    .gameState                   (gameState),
    .playerScore                 (playerScore),
    .computerScore               (computerScore),
    .ballSpeed                   (ballSpeed),
    .countdown                   (countdown),
    .serveRight                  (serveRight)
  );

  function automatic vecT mkVec(input logic [7:0] b, input logic l, input logic r,
                                input logic pp, input logic cp, input int reps,
                                input int st, input int ps, input int cs,
                                input int spd, input int cd, input int sr);
    vecT v;
    v.buttons = b; v.left = l; v.right = r; v.pPad = pp; v.cPad = cp;
    v.reps = reps; v.expState = st; v.expPlayer = ps; v.expComputer = cs;
    v.expSpeed = spd; v.expCountdown = cd; v.expServeRight = sr;
    return v;
  endfunction

  function automatic int modelSpeed();
    int s;
    s = BASE_SPEED + mHitsSinceServe / HITS_PER_STEP;
    return (s > MAX_SPEED) ? MAX_SPEED : s;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mState = ST_TITLE; mPlayer = 0; mComputer = 0; mHitsSinceServe = 0;
    mCountdown = 0; mServeRight = 1;
    mPrevStart = 1'b0; mPrevPause = 1'b0; mPrevPaddle = 1'b0;
  endtask

  task automatic modelEnterServe();
    mState = ST_SERVE;
    mCountdown = SERVE_FRAMES - 1;
    mHitsSinceServe = 0;
  endtask

  task automatic modelScore(input bit computerGoal);
    if (computerGoal) begin
      mComputer++;
      mServeRight = 1;
    end else begin
      mPlayer++;
      mServeRight = 0;
    end
    if (mComputer == WIN_SCORE || mPlayer == WIN_SCORE) begin
      mState = ST_GAMEOVER;
    end else begin
      mState = ST_GOAL;
      mCountdown = GOAL_FRAMES - 1;
    end
  endtask

  task automatic modelTick(input logic [7:0] b, input logic l, input logic r,
                           input logic pp, input logic cp);
    bit startPress, pausePress, hit;
    startPress = b[0] && !mPrevStart;
    pausePress = b[1] && !mPrevPause;
    hit        = (pp || cp) && !mPrevPaddle;
`ifndef MATCH_SEQUENCER_PAUSE_EN
    pausePress = 1'b0;
`endif
    case (mState)
      ST_TITLE, ST_GAMEOVER: begin
        if (startPress) begin
          mPlayer = 0; mComputer = 0; mServeRight = 1;
          modelEnterServe();
        end
      end
      ST_SERVE: begin
        if (mCountdown == 0) mState = ST_PLAYING;
        else mCountdown--;
      end
      ST_PLAYING: begin
        if (pausePress) mState = ST_PAUSED;
        else if (l) modelScore(1'b1);
        else if (r) modelScore(1'b0);
        else if (hit) mHitsSinceServe++;
      end
      ST_GOAL: begin
        if (mCountdown == 0) modelEnterServe();
        else mCountdown--;
      end
      ST_PAUSED: begin
        if (startPress) begin
          mState = ST_TITLE; mPlayer = 0; mComputer = 0;
        end else if (pausePress) begin
          mState = ST_PLAYING;
        end
      end
      default: ;
    endcase
    mPrevStart  = b[0];
    mPrevPause  = b[1];
    mPrevPaddle = pp || cp;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".gameState"}, int'(gameState), mState);
    checkOutput({tag, ".playerScore"}, int'(playerScore), mPlayer);
    checkOutput({tag, ".computerScore"}, int'(computerScore), mComputer);
    checkOutput({tag, ".ballSpeed"}, int'(ballSpeed), modelSpeed());
    checkOutput({tag, ".countdown"}, int'(countdown), mCountdown);
    checkOutput({tag, ".serveRight"}, int'(serveRight), mServeRight);
  endtask

  // One frame: drive inputs, pulse vSyncStart across one edge, sample 1ns later.
  task automatic applyStimulus(input logic [7:0] b, input logic l, input logic r,
                               input logic pp, input logic cp);
    buttons = b;
    collisionBallScreenLeft = l;
    collisionBallScreenRight = r;
    collisionBallPlayerPaddle = pp;
    collisionBallComputerPaddle = cp;
    vSyncStart = 1'b1;
    @(posedge pixelClock);
    #1;
    vSyncStart = 1'b0;
    modelTick(b, l, r, pp, cp);
  endtask

  task automatic idleEdge();
    @(posedge pixelClock);
    #1;
  endtask

  task automatic doReset();
    vSyncStart = 1'b0; buttons = 8'h00;
    collisionBallScreenLeft = 1'b0; collisionBallScreenRight = 1'b0;
    collisionBallPlayerPaddle = 1'b0; collisionBallComputerPaddle = 1'b0;
    resetN = 1'b0;
    repeat (2) @(posedge pixelClock);
    #1;
    resetN = 1'b1;
    modelReset();
  endtask

  task automatic toPlaying();
    doReset();
    applyStimulus(8'h01, 0, 0, 0, 0);
    repeat (SERVE_FRAMES) applyStimulus(8'h00, 0, 0, 0, 0);
    checkOutput("toPlaying.gameState", int'(gameState), ST_PLAYING);
  endtask

  initial begin
    // Directed frame table starting from reset: serve timing, held contact,
    // speed step, goals from both edges, simultaneous edges, goal beats hit.
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0,   1, 0, 0, 0, 5,   0, 1));
    vectors.push_back(mkVec(8'h01, 0, 0, 0, 0,   1, 1, 0, 0, 5, 119, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0, 119, 1, 0, 0, 5,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0,   1, 2, 0, 0, 5,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 1, 0,   5, 2, 0, 0, 5,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0,   1, 2, 0, 0, 5,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 1,   1, 2, 0, 0, 5,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0,   1, 2, 0, 0, 5,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 1, 0,   1, 2, 0, 0, 5,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0,   1, 2, 0, 0, 5,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 1,   1, 2, 0, 0, 6,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0,   1, 2, 0, 0, 6,   0, 1));
    vectors.push_back(mkVec(8'h00, 0, 1, 0, 0,   1, 3, 1, 0, 6,  59, 0));
    vectors.push_back(mkVec(8'h00, 0, 1, 0, 0,  59, 3, 1, 0, 6,   0, 0));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0,   1, 1, 1, 0, 5, 119, 0));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0, 120, 2, 1, 0, 5,   0, 0));
    vectors.push_back(mkVec(8'h00, 1, 1, 0, 0,   1, 3, 1, 1, 5,  59, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0,  60, 1, 1, 1, 5, 119, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0, 120, 2, 1, 1, 5,   0, 1));
    vectors.push_back(mkVec(8'h00, 1, 0, 1, 0,   1, 3, 1, 2, 5,  59, 1));
    vectors.push_back(mkVec(8'h00, 0, 0, 0, 0,  60, 1, 1, 2, 5, 119, 1));

    doReset();
    checkOutput("reset.gameState", int'(gameState), ST_TITLE);
    checkOutput("reset.ballSpeed", int'(ballSpeed), BASE_SPEED);
    checkOutput("reset.serveRight", int'(serveRight), 1);

    foreach (vectors[i]) begin
      string tag;
      repeat (vectors[i].reps)
        applyStimulus(vectors[i].buttons, vectors[i].left, vectors[i].right,
                      vectors[i].pPad, vectors[i].cPad);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, ".gameState"}, int'(gameState), vectors[i].expState);
      checkOutput({tag, ".playerScore"}, int'(playerScore), vectors[i].expPlayer);
      checkOutput({tag, ".computerScore"}, int'(computerScore), vectors[i].expComputer);
      checkOutput({tag, ".ballSpeed"}, int'(ballSpeed), vectors[i].expSpeed);
      checkOutput({tag, ".countdown"}, int'(countdown), vectors[i].expCountdown);
      checkOutput({tag, ".serveRight"}, int'(serveRight), vectors[i].expServeRight);
    end

    // Asynchronous reset in the middle of a serve, checked before any edge.
    doReset();
    applyStimulus(8'h01, 0, 0, 0, 0);
    repeat (79) applyStimulus(8'h00, 0, 0, 0, 0);
    checkOutput("midServe.countdown", int'(countdown), 40);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("asyncReset.gameState", int'(gameState), ST_TITLE);
    checkOutput("asyncReset.playerScore", int'(playerScore), 0);
    checkOutput("asyncReset.computerScore", int'(computerScore), 0);
    checkOutput("asyncReset.ballSpeed", int'(ballSpeed), BASE_SPEED);
    checkOutput("asyncReset.countdown", int'(countdown), 0);
    #1;
    resetN = 1'b1;
    modelReset();

    // Speed ramp: 9 isolated hits, then saturation after 40 more.
    toPlaying();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'h00, 0, 0, 1, 0);
      applyStimulus(8'h00, 0, 0, 0, 0);
    end
    checkOutput("nineHits.ballSpeed", int'(ballSpeed), 7);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'h00, 0, 0, i[0], ~i[0]);
      applyStimulus(8'h00, 0, 0, 0, 0);
    end
    checkOutput("saturate.ballSpeed", int'(ballSpeed), MAX_SPEED);

    // Player reaches WIN_SCORE, GAMEOVER holds, start press restarts.
    toPlaying();
    for (int g = 0; g < WIN_SCORE - 1; g++) begin
      applyStimulus(8'h00, 0, 1, 0, 0);
      repeat (GOAL_FRAMES + SERVE_FRAMES) applyStimulus(8'h00, 0, 0, 0, 0);
    end
    checkOutput("six.playerScore", int'(playerScore), 6);
    checkOutput("six.gameState", int'(gameState), ST_PLAYING);
    applyStimulus(8'h00, 0, 1, 0, 0);
    checkOutput("win.playerScore", int'(playerScore), 7);
    checkOutput("win.gameState", int'(gameState), ST_GAMEOVER);
    repeat (5) applyStimulus(8'h00, 1, 1, 1, 1);
    checkOutput("over.playerScore", int'(playerScore), 7);
    checkOutput("over.computerScore", int'(computerScore), 0);
    checkOutput("over.gameState", int'(gameState), ST_GAMEOVER);
    applyStimulus(8'h01, 0, 0, 0, 0);
    checkOutput("restart.gameState", int'(gameState), ST_SERVE);
    checkOutput("restart.playerScore", int'(playerScore), 0);
    checkOutput("restart.serveRight", int'(serveRight), 1);
    checkOutput("restart.countdown", int'(countdown), SERVE_FRAMES - 1);

    // Pause button behaviour.
    toPlaying();
`ifdef MATCH_SEQUENCER_PAUSE_EN
    applyStimulus(8'h02, 0, 0, 0, 0);
    checkOutput("pause.gameState", int'(gameState), ST_PAUSED);
    applyStimulus(8'h00, 1, 0, 0, 0);
    checkOutput("paused.computerScore", int'(computerScore), 0);
    checkOutput("paused.gameState", int'(gameState), ST_PAUSED);
    applyStimulus(8'h02, 0, 0, 0, 0);
    checkOutput("resume.gameState", int'(gameState), ST_PLAYING);
`else
    applyStimulus(8'h02, 0, 0, 0, 0);
    checkOutput("pauseIgnored.gameState", int'(gameState), ST_PLAYING);
`endif

    // Randomized frames against the reference model, with idle clock
    // edges between some frames to confirm nothing moves without a tick.
    doReset();
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      b[0] = ($urandom_range(0, 7) == 0);
      b[1] = ($urandom_range(0, 9) == 0);
      applyStimulus(b, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      if ((n % 50) == 0) checkModel($sformatf("rand%0d", n));
      else begin
        checkOutput("rand.gameState", int'(gameState), mState);
        checkOutput("rand.ballSpeed", int'(ballSpeed), modelSpeed());
        checkOutput("rand.countdown", int'(countdown), mCountdown);
      end
      if ($urandom_range(0, 3) == 0) begin
        idleEdge();
        checkModel("randIdle");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
